// File: rtl/matador_stream_sequencer.sv
// rtl/matador_stream_sequencer.sv - frames a word stream into datapoints/batches for the inference core with credit-limited issue
module matador_stream_sequencer #(
    parameter int C_S00_AXIS_DATA_WIDTH = 64,
    parameter int NUM_PACKETS           = 13,
    parameter int DATAPOINTS            = 10,
    parameter int MAX_OUTSTANDING       = 2
) (
    input  logic                                 s00_axis_aclk,
    input  logic                                 s00_axis_areset,
    input  logic                                 start,
    input  logic [C_S00_AXIS_DATA_WIDTH-1:0]     s00_axis_tdata,
    input  logic                                 s00_axis_tvalid,
    input  logic                                 s00_axis_tlast,
    output logic                                 s00_axis_tready,
    output logic [C_S00_AXIS_DATA_WIDTH-1:0]     core_data,
    output logic                                 core_valid,
    input  logic                                 core_ready,
    output logic                                 core_first,
    output logic                                 core_dp_last,
    output logic [$clog2(NUM_PACKETS)-1:0]       core_pkt_idx,
    input  logic                                 result_valid,
    output logic                                 busy,
    output logic                                 batch_done,
    output logic                                 err_early_last,
    output logic                                 err_missing_last
);

    localparam int PKT_W = $clog2(NUM_PACKETS);
    localparam int DP_W  = (DATAPOINTS > 1) ? $clog2(DATAPOINTS) : 1;
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(NUM_PACKETS - 1);
    localparam logic [DP_W-1:0]  DP_LAST  = DP_W'(DATAPOINTS - 1);
    localparam logic [OUT_W-1:0] OUT_MAX  = OUT_W'(MAX_OUTSTANDING);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;

    logic [1:0]       state;
    logic [PKT_W-1:0] pkt_cnt;
    logic [DP_W-1:0]  dp_cnt;
    logic [OUT_W-1:0] outstanding;

    logic gate;
    logic xfer;
    logic last_expected;
    logic credit_take;
    logic credit_give;

    // A new datapoint may only begin while a credit is free; words inside an
    // already-started datapoint always flow. Only the registered credit count
    // is consulted, so a result returning this cycle opens the gate next cycle.
    assign gate = (state == S_STREAM) && ((pkt_cnt != '0) || (outstanding < OUT_MAX));

    assign s00_axis_tready = core_ready && gate;
    assign core_valid      = s00_axis_tvalid && gate;
    assign core_data       = s00_axis_tdata;
    assign xfer            = s00_axis_tvalid && s00_axis_tready;

    assign core_pkt_idx = pkt_cnt;
    assign core_first   = (pkt_cnt == '0);
    assign core_dp_last = (pkt_cnt == PKT_LAST);

    assign last_expected = (dp_cnt == DP_LAST) && (pkt_cnt == PKT_LAST);
    assign credit_take   = xfer && (pkt_cnt == '0);
    assign credit_give   = result_valid && (outstanding != '0);

    assign busy       = (state != S_IDLE);
    assign batch_done = (state == S_DRAIN) && (outstanding == '0);

    // Batch framing FSM: word/datapoint position counters and sticky tlast checks
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            state            <= S_IDLE;
            pkt_cnt          <= '0;
            dp_cnt           <= '0;
            err_early_last   <= 1'b0;
            err_missing_last <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state            <= S_STREAM;
                        pkt_cnt          <= '0;
                        dp_cnt           <= '0;
                        err_early_last   <= 1'b0;
                        err_missing_last <= 1'b0;
                    end
                end
                S_STREAM: begin
                    if (xfer) begin
                        if (last_expected || s00_axis_tlast) begin
                            state   <= S_DRAIN;
                            pkt_cnt <= '0;
                            dp_cnt  <= '0;
                            if (last_expected) begin
                                if (!s00_axis_tlast) begin
                                    err_missing_last <= 1'b1;
                                end
                            end else begin
                                err_early_last <= 1'b1;
                            end
                        end else if (pkt_cnt == PKT_LAST) begin
                            pkt_cnt <= '0;
                            dp_cnt  <= dp_cnt + 1'b1;
                        end else begin
                            pkt_cnt <= pkt_cnt + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (outstanding == '0) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Datapoints in flight: taken when a datapoint's first word issues, returned on result_valid
    always_ff @(posedge s00_axis_aclk) begin
        if (s00_axis_areset) begin
            outstanding <= '0;
        end else if (credit_take && !credit_give) begin
            outstanding <= outstanding + 1'b1;
        end else if (!credit_take && credit_give) begin
            outstanding <= outstanding - 1'b1;
        end
    end

endmodule

// File: tb/tb_matador_stream_sequencer.sv
// tb/tb_matador_stream_sequencer.sv - scoreboard bench for matador_stream_sequencer
module tb_matador_stream_sequencer;

    localparam int NP    = 13;
    localparam int DP    = 10;
    localparam int MAXO  = 2;
    localparam int BATCH = NP * DP;

    logic        clk = 1'b0;
    logic        areset = 1'b1;
    logic        start = 1'b0;
    logic [63:0] tdata = '0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic        tready;
    logic [63:0] core_data;
    logic        core_valid;
    logic        core_ready = 1'b1;
    logic        core_first;
    logic        core_dp_last;
    logic [3:0]  core_pkt_idx;
    logic        result_auto = 1'b0;
    logic        result_man = 1'b0;
    logic        result_valid;
    logic        busy;
    logic        batch_done;
    logic        err_early_last;
    logic        err_missing_last;

    assign result_valid = result_auto | result_man;

    always #5 clk = ~clk;

    matador_stream_sequencer #(
        .C_S00_AXIS_DATA_WIDTH(64),
        .NUM_PACKETS(NP),
        .DATAPOINTS(DP),
        .MAX_OUTSTANDING(MAXO)
    ) dut (
        .s00_axis_aclk(clk),
        .s00_axis_areset(areset),
        .start(start),
        .s00_axis_tdata(tdata),
        .s00_axis_tvalid(tvalid),
        .s00_axis_tlast(tlast),
        .s00_axis_tready(tready),
        .core_data(core_data),
        .core_valid(core_valid),
        .core_ready(core_ready),
        .core_first(core_first),
        .core_dp_last(core_dp_last),
        .core_pkt_idx(core_pkt_idx),
        .result_valid(result_valid),
        .busy(busy),
        .batch_done(batch_done),
        .err_early_last(err_early_last),
        .err_missing_last(err_missing_last)
    );

    typedef struct {
        logic [63:0] data;
        int          idx;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_xfer = 0;
    int   n_first = 0;
    int   n_dplast = 0;
    int   n_done = 0;
    bit   auto_res = 1'b0;
    bit   rand_ready = 1'b0;

    // reference model: batch progress as a word position plus datapoints in flight
    bit m_busy = 1'b0;
    bit m_drain = 1'b0;
    bit m_early = 1'b0;
    bit m_miss = 1'b0;
    int m_pos = 0;
    int m_inflight = 0;

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: per-cycle comparison against the model, scoreboard pop on each transfer
    initial forever begin
        @(negedge clk);
        if (areset) begin
            m_busy = 1'b0; m_drain = 1'b0; m_early = 1'b0; m_miss = 1'b0;
            m_pos = 0; m_inflight = 0;
        end else begin
            bit   m_gate;
            bit   xfer;
            bit   take;
            exp_t e;
            m_gate = m_busy && !m_drain && (((m_pos % NP) != 0) || (m_inflight < MAXO));
            check_bit("tready", tready, core_ready && m_gate);
            check_bit("core_valid", core_valid, tvalid && m_gate);
            check_val("core_data_passthru", core_data, tdata);
            check_val("core_pkt_idx", 64'(core_pkt_idx), 64'(m_pos % NP));
            check_bit("core_first", core_first, (m_pos % NP) == 0);
            check_bit("core_dp_last", core_dp_last, (m_pos % NP) == NP - 1);
            check_bit("busy", busy, m_busy);
            check_bit("batch_done", batch_done, m_drain && (m_inflight == 0));
            check_bit("err_early_last", err_early_last, m_early);
            check_bit("err_missing_last", err_missing_last, m_miss);
            xfer = tvalid && tready;
            if (batch_done) n_done++;
            if (xfer) begin
                n_xfer++;
                if (core_first) n_first++;
                if (core_dp_last) n_dplast++;
                if (sb.size() == 0) begin
                    check_bit("unexpected_transfer", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    check_val("word_data", core_data, e.data);
                    check_val("word_idx", 64'(core_pkt_idx), 64'(e.idx % NP));
                end
                if (core_dp_last && auto_res) begin
                    fork
                        begin
                            repeat (5) @(posedge clk);
                            #1 result_auto = 1'b1;
                            @(posedge clk);
                            #1 result_auto = 1'b0;
                        end
                    join_none
                end
            end
            take = 1'b0;
            if (m_drain && m_inflight == 0) begin
                m_busy = 1'b0; m_drain = 1'b0;
            end else if (!m_busy && start) begin
                m_busy = 1'b1; m_pos = 0; m_early = 1'b0; m_miss = 1'b0;
            end else if (m_busy && !m_drain && xfer) begin
                take = (m_pos % NP) == 0;
                if (m_pos == BATCH - 1) begin
                    m_drain = 1'b1; m_miss = m_miss | !tlast; m_pos = 0;
                end else if (tlast) begin
                    m_drain = 1'b1; m_early = 1'b1; m_pos = 0;
                end else begin
                    m_pos++;
                end
            end
            if (take && !(result_valid && m_inflight > 0)) m_inflight++;
            else if (!take && result_valid && m_inflight > 0) m_inflight--;
        end
    end

    // core back-pressure: always ready unless randomized
    initial forever begin
        @(posedge clk);
        #1 core_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_result();
        result_man = 1'b1;
        tick();
        result_man = 1'b0;
    endtask

    task automatic present_word(input int k, input bit last);
        exp_t e;
        e.data = {$urandom, $urandom};
        e.idx  = k;
        sb.push_back(e);
        tdata  = e.data;
        tlast  = last;
        tvalid = 1'b1;
    endtask

    task automatic send_word(input int k, input bit last);
        int n;
        present_word(k, last);
        n = 0;
        @(negedge clk);
        while (!tready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!tready) begin
            check_bit("handshake_timeout", 1'b0, 1'b1);
            sb.delete(sb.size() - 1);
        end
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (!batch_done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check_bit(name, batch_done, 1'b1);
        tick();
    endtask

    int x0, f0, l0, d0;

    initial begin
        repeat (3) tick();
        areset = 1'b0;
        @(negedge clk);
        check_bit("reset_tready", tready, 1'b0);
        check_bit("reset_busy", busy, 1'b0);
        check_bit("reset_first", core_first, 1'b1);
        check_val("reset_pkt_idx", 64'(core_pkt_idx), 64'd0);
        check_bit("reset_errs", err_early_last | err_missing_last | batch_done, 1'b0);
        tick();

        // nominal batch
        auto_res = 1'b1;
        x0 = n_xfer; f0 = n_first; l0 = n_dplast; d0 = n_done;
        do_start();
        for (int k = 0; k < BATCH; k++) send_word(k, k == BATCH - 1);
        wait_done("nominal_done");
        check_val("nominal_xfers", 64'(n_xfer - x0), 64'd130);
        check_val("nominal_firsts", 64'(n_first - f0), 64'd10);
        check_val("nominal_dplasts", 64'(n_dplast - l0), 64'd10);
        check_val("nominal_done_pulses", 64'(n_done - d0), 64'd1);
        @(negedge clk);
        check_bit("nominal_idle", busy, 1'b0);
        check_bit("nominal_no_err", err_early_last | err_missing_last, 1'b0);
        tick();

        // credit stall with results withheld, then early tlast
        auto_res = 1'b0;
        do_start();
        for (int k = 0; k < 26; k++) send_word(k, 1'b0);
        present_word(26, 1'b0);
        repeat (6) begin
            @(negedge clk);
            check_bit("credit_stall", tready, 1'b0);
        end
        tick();
        result_man = 1'b1;
        @(negedge clk);
        check_bit("stall_same_cycle_result", tready, 1'b0);
        tick();
        result_man = 1'b0;
        @(negedge clk);
        check_bit("stall_release_next_cycle", tready, 1'b1);
        tick();
        tvalid = 1'b0;
        for (int k = 27; k <= 50; k++) begin
            if (k % NP == 0) pulse_result();
            send_word(k, k == 50);
        end
        @(negedge clk);
        check_bit("early_flag", err_early_last, 1'b1);
        check_bit("early_drain_busy", busy, 1'b1);
        check_bit("early_no_done_yet", batch_done, 1'b0);
        tick();
        pulse_result();
        pulse_result();
        wait_done("early_done");
        do_start();
        @(negedge clk);
        check_bit("start_clears_early", err_early_last, 1'b0);
        tick();

        // missing tlast, then an extra word that must not be accepted
        auto_res = 1'b1;
        x0 = n_xfer;
        for (int k = 0; k < BATCH; k++) send_word(k, 1'b0);
        @(negedge clk);
        check_bit("missing_flag", err_missing_last, 1'b1);
        tick();
        tdata = 64'hdead_beef_0000_0001;
        tlast = 1'b1;
        tvalid = 1'b1;
        wait_done("missing_done");
        repeat (5) tick();
        check_val("missing_no_extra_word", 64'(n_xfer - x0), 64'd130);
        tvalid = 1'b0;
        tlast = 1'b0;
        do_start();
        @(negedge clk);
        check_bit("start_clears_missing", err_missing_last, 1'b0);
        tick();

        // reset during word 40 of a batch
        for (int k = 0; k < 40; k++) send_word(k, 1'b0);
        tdata = 64'h1234;
        tvalid = 1'b1;
        areset = 1'b1;
        tick();
        areset = 1'b0;
        tvalid = 1'b0;
        @(negedge clk);
        check_bit("midreset_tready", tready, 1'b0);
        check_bit("midreset_busy", busy, 1'b0);
        check_bit("midreset_errs", err_early_last | err_missing_last, 1'b0);
        check_bit("midreset_first", core_first, 1'b1);
        tick();
        repeat (10) tick();
        auto_res = 1'b0;
        do_start();
        for (int k = 0; k < BATCH; k++) begin
            if (k >= 2 * NP && k % NP == 0) pulse_result();
            send_word(k, k == BATCH - 1);
        end
        pulse_result();
        pulse_result();
        wait_done("postreset_done");

        // randomized back-pressure and gaps
        auto_res = 1'b1;
        rand_ready = 1'b1;
        do_start();
        for (int k = 0; k < BATCH; k++) begin
            send_word(k, k == BATCH - 1);
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_done("random_done");
        rand_ready = 1'b0;
        repeat (10) tick();
        check_val("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
